mem_rmw_port: RTL

Request/response front end for one port of the team's dual-port synchronous RAM. That RAM has whole-word writes only and registered read data with 1-cycle latency. This block accepts CPU-side word requests with byte enables and issues RAM port cycles. Partial writes become a read-modify-write sequence. Read data and write acknowledges are returned on a valid-only response channel.

---
 rtl/mem_rmw_port_pkg.sv | 27 ++
 rtl/mem_rmw_port_if.sv | 28 ++
 rtl/mem_rmw_port_byte_merge.sv | 24 ++
 rtl/mem_rmw_port.sv | 103 ++++++++++
 4 files changed

// File: rtl/mem_rmw_port_pkg.sv
// Shared types and helpers for the mem_rmw_port RAM front end.
// Holds the FSM state encoding and the per-byte merge used by read-modify-write.
package mem_rmw_port_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WACK = 2'd2,
    ST_RMW  = 2'd3
  } state_e;

  // One byte lane of the RMW merge: the enabled lane takes the new data.
  function automatic logic [BYTE_W-1:0] merge(input logic [BYTE_W-1:0] old_byte,
                                              input logic [BYTE_W-1:0] new_byte,
                                              input logic              be);
    logic [BYTE_W-1:0] res;
    if (be) begin
      res = new_byte;
    end else begin
      res = old_byte;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_rmw_port_if.sv
// CPU-side request/response channel of mem_rmw_port.
// The master issues word requests; the slave returns valid-only responses.
interface mem_rmw_port_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
);
  localparam int BWIDTH = DWIDTH / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic [BWIDTH-1:0] req_be;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_rmw_port_byte_merge.sv
// Combinational byte-lane merge for the RMW write-back word:
// each lane takes new data where its enable is set, else keeps the RAM data.
module mem_rmw_port_byte_merge
  import mem_rmw_port_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0]        i_old,
  input  logic [DWIDTH-1:0]        i_new,
  input  logic [DWIDTH/BYTE_W-1:0] i_be,
  output logic [DWIDTH-1:0]        o_data
);
  localparam int BWIDTH = DWIDTH / BYTE_W;

  always_comb begin
    o_data = '0;
    for (int i = 0; i < BWIDTH; i++) begin
      o_data[BYTE_W*i +: BYTE_W] = merge(i_old[BYTE_W*i +: BYTE_W],
                                         i_new[BYTE_W*i +: BYTE_W],
                                         i_be[i]);
    end
  end

endmodule

// File: rtl/mem_rmw_port.sv
// One-port front end for the whole-word synchronous RAM: turns byte-enabled
// CPU requests into RAM cycles, using read-modify-write for partial writes.
module mem_rmw_port
  import mem_rmw_port_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  mem_rmw_port_if.slave     bus,
  output logic [AWIDTH-1:0] o_ram_addr,
  output logic [DWIDTH-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic [DWIDTH-1:0] i_ram_rdata
);
  localparam int BWIDTH = DWIDTH / BYTE_W;

  state_e            r_state;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [BWIDTH-1:0] r_be;

  state_e            w_state_nxt;
  logic              w_latch;
  logic              w_accept;
  logic [DWIDTH-1:0] w_merged;

  // Reset gates the handshake so nothing is accepted while reset_n is low.
  assign bus.req_ready = i_reset_n & (r_state != ST_RMW);
  assign w_accept      = bus.req_valid & bus.req_ready;

  mem_rmw_port_byte_merge #(.DWIDTH(DWIDTH)) u_merge (
    .i_old  (i_ram_rdata),
    .i_new  (r_wdata),
    .i_be   (r_be),
    .o_data (w_merged)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end
    end
  end

  always_comb begin
    w_state_nxt   = ST_IDLE;
    w_latch       = 1'b0;
    o_ram_addr    = '0;
    o_ram_wdata   = '0;
    o_ram_we      = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;

    case (r_state)
      ST_RD: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = i_ram_rdata;
      end
      ST_WACK: begin
        bus.rsp_valid = 1'b1;
      end
      default: begin
        bus.rsp_valid = 1'b0;
      end
    endcase

    if (r_state == ST_RMW) begin
      // Write-back commits only if reset is not pulling the operation down.
      o_ram_addr  = r_addr;
      o_ram_wdata = w_merged;
      o_ram_we    = i_reset_n;
      w_state_nxt = ST_WACK;
    end else if (w_accept) begin
      o_ram_addr = bus.req_addr;
      if (!bus.req_we) begin
        w_state_nxt = ST_RD;
      end else if (&bus.req_be) begin
        o_ram_we    = 1'b1;
        o_ram_wdata = bus.req_wdata;
        w_state_nxt = ST_WACK;
      end else if (bus.req_be == '0) begin
        w_state_nxt = ST_WACK;
      end else begin
        w_latch     = 1'b1;
        w_state_nxt = ST_RMW;
      end
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

endmodule
